// File: rtl/eth_reset_seq.sv
// Ethernet reset sequencer: filters the clock-generator lock, pulses the PHY reset,
// waits for the PHY to settle, then releases the core reset and raises ready.
module eth_reset_seq #(
    parameter int LOCK_CYCLES    = 1024,
    parameter int PHY_RST_CYCLES = 1250000,
    parameter int SETTLE_CYCLES  = 125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mmcm_locked,
    input  logic       restart_req,
    output logic       phy_reset_n,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int MAX_LP     = (LOCK_CYCLES > PHY_RST_CYCLES) ? LOCK_CYCLES : PHY_RST_CYCLES;
    localparam int MAX_CYCLES = (MAX_LP > SETTLE_CYCLES) ? MAX_LP : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOCK_FILT = 3'd1,
        ST_PHY_RST   = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lock_meta;
    logic             lock_s;
    logic             loss_inc;
    logic [7:0]       loss_q;
    logic             phy_reset_n_q;
    logic             core_rst_q;
    logic             ready_q;

    // Two-flop synchronizer; nothing downstream looks at mmcm_locked directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // restart_req is a one-cycle strobe sampled on clk; it only has meaning in RUN,
    // and a simultaneous lock loss wins over it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        loss_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = ST_LOCK_FILT;
                end
            end
            ST_LOCK_FILT: begin
                if (!lock_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_PHY_RST;
                end
            end
            ST_PHY_RST: begin
                if (!lock_s) begin
                    state_d  = ST_IDLE;
                    loss_inc = 1'b1;
                end else if (cnt_q == PHY_LAST) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d  = ST_IDLE;
                    loss_inc = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = ST_IDLE;
                    loss_inc = 1'b1;
                end else if (restart_req) begin
                    state_d = ST_PHY_RST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_reset_n_q <= 1'b0;
            core_rst_q    <= 1'b1;
            ready_q       <= 1'b0;
            loss_q        <= 8'd0;
        end else begin
            phy_reset_n_q <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
            core_rst_q    <= (state_d != ST_RUN);
            ready_q       <= (state_d == ST_RUN);
            if (loss_inc && (loss_q != 8'hFF)) begin
                loss_q <= loss_q + 8'd1;
            end
        end
    end

    assign phy_reset_n = phy_reset_n_q;
    assign core_rst    = core_rst_q;
    assign ready       = ready_q;
    assign loss_count  = loss_q;
    assign state       = state_q;

endmodule

// File: tb/tb_eth_reset_seq.sv
// Bench for eth_reset_seq: directed scenarios plus random lock/restart traffic,
// checked every cycle against a timeline model of the reset sequence.
module tb_eth_reset_seq;

    localparam int L    = 4;
    localparam int P    = 8;
    localparam int S    = 6;
    localparam int FULL = 2 + L + P + S;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mmcm_locked;
    logic       restart_req;
    logic       phy_reset_n;
    logic       core_rst;
    logic       ready;
    logic [7:0] loss_count;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n;

    // Model: when active, the sequence position is (edge_n - m_mark) edges into LOCK_FILT.
    bit   m_active;
    int   m_mark;
    int   m_loss;
    logic lock_hist[$];

    always #4 clk = ~clk;

    eth_reset_seq #(
        .LOCK_CYCLES   (L),
        .PHY_RST_CYCLES(P),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmcm_locked(mmcm_locked),
        .restart_req(restart_req),
        .phy_reset_n(phy_reset_n),
        .core_rst   (core_rst),
        .ready      (ready),
        .loss_count (loss_count),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_mark   = 0;
        m_loss   = 0;
        edge_n   = -1;
        lock_hist.delete();
        lock_hist.push_back(1'b0);
        lock_hist.push_back(1'b0);
    endtask

    task automatic step();
        logic ls;
        int   e_prev;
        int   e;
        int   es;
        int   ep;
        int   ec;
        int   er;
        @(posedge clk);
        edge_n++;
        ls = lock_hist.pop_front();
        lock_hist.push_back(mmcm_locked);
        if (!m_active) begin
            if (ls) begin
                m_active = 1'b1;
                m_mark   = edge_n;
            end
        end else begin
            e_prev = edge_n - 1 - m_mark;
            if (!ls) begin
                m_active = 1'b0;
                if (e_prev >= L && m_loss < 255) m_loss++;
            end else if (restart_req && e_prev >= L + P + S) begin
                m_mark = edge_n - L;
            end
        end
        if (!m_active) begin
            es = 0; ep = 0; ec = 1; er = 0;
        end else begin
            e = edge_n - m_mark;
            if (e < L) begin
                es = 1; ep = 0; ec = 1; er = 0;
            end else if (e < L + P) begin
                es = 2; ep = 0; ec = 1; er = 0;
            end else if (e < L + P + S) begin
                es = 3; ep = 1; ec = 1; er = 0;
            end else begin
                es = 4; ep = 1; ec = 0; er = 1;
            end
        end
        #1;
        check("state", 32'(state), es);
        check("phy_reset_n", 32'(phy_reset_n), ep);
        check("core_rst", 32'(core_rst), ec);
        check("ready", 32'(ready), er);
        check("loss_count", 32'(loss_count), m_loss);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_ready(input int budget, output int rise, output int phy_rise);
        rise     = -1;
        phy_rise = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (phy_rise < 0 && phy_reset_n) phy_rise = edge_n;
            if (ready) begin
                rise = edge_n;
                break;
            end
        end
    endtask

    // Asserts reset between clock edges, checks outputs immediately, releases with lock_val.
    task automatic do_reset(input logic lock_val);
        @(negedge clk);
        rst_n       = 1'b0;
        mmcm_locked = 1'b0;
        restart_req = 1'b0;
        #1;
        model_reset();
        check("rst_state", 32'(state), 0);
        check("rst_phy_reset_n", 32'(phy_reset_n), 0);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_ready", 32'(ready), 0);
        check("rst_loss_count", 32'(loss_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mmcm_locked = lock_val;
        rst_n       = 1'b1;
    endtask

    initial begin
        int rise;
        int phy_rise;
        int e0;
        int r;
        int low_cnt;

        rst_n       = 1'b0;
        mmcm_locked = 1'b0;
        restart_req = 1'b0;
        model_reset();

        // Lock glitch inside the filter window: filter restarts, no loss counted.
        do_reset(1'b0);
        mmcm_locked = 1'b1;
        run(3);
        mmcm_locked = 1'b0;
        run(1);
        mmcm_locked = 1'b1;
        e0 = edge_n + 1;
        run_until_ready(60, rise, phy_rise);
        check("glitch_ready_latency", rise - e0, FULL);
        check("glitch_phy_rise", phy_rise - e0, 2 + L + P);
        check("glitch_loss", 32'(loss_count), 0);

        // Clean power-up: lock stable from edge 0.
        do_reset(1'b1);
        run_until_ready(40, rise, phy_rise);
        check("powerup_ready_edge", rise, FULL);
        check("powerup_phy_rise_edge", phy_rise, 14);
        check("powerup_loss", 32'(loss_count), 0);

        // Lock loss in RUN, then relock.
        run(3);
        mmcm_locked = 1'b0;
        run(3);
        check("loss_core_rst", 32'(core_rst), 1);
        check("loss_phy_reset_n", 32'(phy_reset_n), 0);
        check("loss_ready", 32'(ready), 0);
        check("loss_count_one", 32'(loss_count), 1);
        run(4);
        mmcm_locked = 1'b1;
        e0 = edge_n + 1;
        run_until_ready(40, rise, phy_rise);
        check("relock_ready_latency", rise - e0, FULL);

        // Restart in RUN, then an ignored restart while settling.
        run(2);
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        r = edge_n;
        low_cnt = phy_reset_n ? 0 : 1;
        for (int i = 0; i < 20 && !phy_reset_n; i++) begin
            step();
            if (!phy_reset_n) low_cnt++;
        end
        check("restart_phy_low_len", low_cnt, P);
        step();
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        run_until_ready(30, rise, phy_rise);
        check("restart_ready_latency", rise - r, P + S);
        check("restart_loss_unchanged", 32'(loss_count), 1);

        // Random lock drops and restart strobes.
        for (int i = 0; i < 600; i++) begin
            mmcm_locked = ($urandom_range(0, 29) != 0);
            restart_req = ($urandom_range(0, 19) == 0);
            step();
        end
        restart_req = 1'b0;

        // 300 lock losses during PHY reset: counter must saturate.
        for (int k = 0; k < 300; k++) begin
            mmcm_locked = 1'b1;
            run(9);
            mmcm_locked = 1'b0;
            run(3);
        end
        check("loss_saturated", 32'(loss_count), 255);

        // Reset pulse mid-PHY_RST, then a full sequence again.
        mmcm_locked = 1'b1;
        run(10);
        check("pre_reset_in_phy_rst", 32'(state), 2);
        do_reset(1'b1);
        run_until_ready(40, rise, phy_rise);
        check("post_reset_ready_edge", rise, FULL);
        check("post_reset_phy_rise_edge", phy_rise, 14);
        check("post_reset_loss", 32'(loss_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_reset_seq.md
ETH_RESET_SEQ -- requirements
Module: eth_reset_seq

Interface
REQ-001 SHALL provide parameter LOCK_CYCLES, default 1024, the number of consecutive synchronized-lock cycles needed before sequencing starts (min 1).
REQ-002 SHALL provide parameter PHY_RST_CYCLES, default 1250000, the phy_reset_n low-pulse length in clk cycles (min 1).
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 125000, the post-PHY-reset settle time before core reset releases (min 1).
REQ-004 SHALL have port clk, input, 1 bit: the 125 MHz system clock; it is the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mmcm_locked, input, 1 bit: the clock-generator lock flag, asynchronous to clk.
REQ-007 SHALL have port restart_req, input, 1 bit: a single-cycle request to re-run the PHY reset.
REQ-008 SHALL have port phy_reset_n, output, 1 bit: the active-low Ethernet PHY reset.
REQ-009 SHALL have port core_rst, output, 1 bit: the active-high synchronous reset driven to the core logic.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port loss_count, output, 8 bits: the number of lock losses, saturating.
REQ-012 SHALL have port state, output, 3 bits: IDLE=0, LOCK_FILT=1, PHY_RST=2, SETTLE=3, RUN=4.

Function
REQ-013 SHALL synchronize mmcm_locked through a 2-flop synchronizer; all decisions SHALL use only the synchronized lock_s.
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement IDLE: when lock_s=1, go to LOCK_FILT with the counter cleared.
REQ-016 SHALL implement LOCK_FILT: count consecutive lock_s=1 cycles; lock_s=0 returns to IDLE with the counter cleared (no loss_count increment); after LOCK_CYCLES consecutive high cycles, go to PHY_RST.
REQ-017 SHALL implement PHY_RST: phy_reset_n=0 for exactly PHY_RST_CYCLES cycles, then go to SETTLE.
REQ-018 SHALL implement SETTLE: phy_reset_n=1 and core_rst=1 for exactly SETTLE_CYCLES cycles, then go to RUN.
REQ-019 SHALL implement RUN: phy_reset_n=1, core_rst=0, ready=1.
REQ-020 SHALL, in IDLE/LOCK_FILT/PHY_RST, drive phy_reset_n=0, core_rst=1 and ready=0.
REQ-021 SHALL, when lock_s=0 in PHY_RST, SETTLE or RUN, enter IDLE on the next edge, force phy_reset_n=0 and core_rst=1 that edge, and increment loss_count.
REQ-022 SHALL saturate loss_count at 255; it SHALL never wrap.
REQ-023 SHALL, when restart_req=1 in RUN with lock_s=1, go to PHY_RST with the counter cleared and loss_count unchanged.
REQ-024 SHALL ignore restart_req in all states other than RUN.
REQ-025 SHALL give lock loss priority when lock loss and restart_req coincide in RUN (IDLE, count+1).
REQ-026 SHALL size the shared cycle counter to $clog2(max(LOCK_CYCLES, PHY_RST_CYCLES, SETTLE_CYCLES)+1) bits; it SHALL clear on every state change.
REQ-027 SHALL make ready rise exactly 2+LOCK_CYCLES+PHY_RST_CYCLES+SETTLE_CYCLES edges after the first edge sampling mmcm_locked=1, for a lock held stable from that edge.

Reset
REQ-028 SHALL, while rst_n=0, immediately (asynchronously) force state=IDLE, phy_reset_n=0, core_rst=1, ready=0, loss_count=0, the counter to 0 and both sync flops to 0.
REQ-029 SHALL, after rst_n deasserts mid-sequence, restart from IDLE; no partial count SHALL be retained.

Verification (LOCK_CYCLES=4, PHY_RST_CYCLES=8, SETTLE_CYCLES=6)
REQ-030 SHALL cover: mmcm_locked high from edge 0 -> phy_reset_n low through edge 13, high from edge 14; core_rst falls and ready rises at edge 20; loss_count=0.
REQ-031 SHALL cover: lock_s high 3 cycles, low 1, then high -> back to IDLE, filter restarts, phy_reset_n stays 0, loss_count=0.
REQ-032 SHALL cover: mmcm_locked dropped in RUN -> within 3 edges core_rst=1, phy_reset_n=0, ready=0, loss_count=1; on relock, ready returns 20 edges after the rise.
REQ-033 SHALL cover: restart_req pulse in RUN -> phy_reset_n low exactly 8 cycles, ready after 14 cycles, loss_count unchanged; restart_req in SETTLE has no effect.
REQ-034 SHALL cover: 300 lock-loss events -> loss_count holds at 255.
REQ-035 SHALL cover: rst_n pulsed low mid-PHY_RST between edges -> outputs at reset values before the next edge; a full 20-cycle sequence is repeated afterwards.
